// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the sliced, multi-cycle adder sequencer.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADD      = 2'd1,
    DONE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int idx_width(input int width, input int slice);
    int n;
    n = width / slice;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry-in/carry-out; one instance is time-shared across slices.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Button-driven operand loader and WIDTH/SLICE-cycle sequenced adder.
// Build option ADDSEQ_ACCUM_EN: the finished Sum is also written into B (running accumulator).
//   state    | meaning
//   IDLE     | waiting for Run press (loads A) or LoadB press (loads B)
//   ADD      | one slice per cycle through adder_slice, carry registered between slices
//   DONE     | result committed; Done pulse is registered out of this state
//   WAIT_REL | hold here until Run is released so a held button never restarts
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
  output logic             Done
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = idx_width(WIDTH, SLICE);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d, partial_q, partial_d;
  logic              co_q, co_d, carry_q, carry_d, done_q, done_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              lb_meta_q, lb_meta_d, lb_s_q, lb_s_d, lb_dly_q, lb_dly_d;
  logic              run_meta_q, run_meta_d, run_s_q, run_s_d, run_dly_q, run_dly_d;

  logic              lb_press, run_press;
  logic [SLICE-1:0]  slice_a, slice_b, slice_s;
  logic              slice_co;

  assign lb_press  = lb_dly_q & ~lb_s_q;
  assign run_press = run_dly_q & ~run_s_q;

  assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      partial_q  <= '0;
      co_q       <= 1'b0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      // Buttons are active-low, so the synchronizers start in the released state.
      lb_meta_q  <= 1'b1;
      lb_s_q     <= 1'b1;
      lb_dly_q   <= 1'b1;
      run_meta_q <= 1'b1;
      run_s_q    <= 1'b1;
      run_dly_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      partial_q  <= partial_d;
      co_q       <= co_d;
      carry_q    <= carry_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      lb_meta_q  <= lb_meta_d;
      lb_s_q     <= lb_s_d;
      lb_dly_q   <= lb_dly_d;
      run_meta_q <= run_meta_d;
      run_s_q    <= run_s_d;
      run_dly_q  <= run_dly_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    partial_d  = partial_q;
    co_d       = co_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    lb_meta_d  = LoadB;
    lb_s_d     = lb_meta_q;
    lb_dly_d   = lb_s_q;
    run_meta_d = Run;
    run_s_d    = run_meta_q;
    run_dly_d  = run_s_q;

    unique case (state_q)
      IDLE: begin
        if (run_press) begin
          a_d       = SW;
          partial_d = '0;
          carry_d   = 1'b0;
          idx_d     = '0;
          state_d   = ADD;
        end else if (lb_press) begin
          b_d = SW;
        end
      end
      ADD: begin
        partial_d[int'(idx_q)*SLICE +: SLICE] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(N-1)) begin
          // partial_d already holds the top slice, so it is the complete sum.
          sum_d   = partial_d;
          co_d    = slice_co;
`ifdef ADDSEQ_ACCUM_EN
          b_d     = partial_d;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (run_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign A    = a_q;
  assign B    = b_q;
  assign Sum  = sum_q;
  assign CO   = co_q;
  assign Busy = (state_q == ADD);
  assign Done = done_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed cases plus randomized load/run sequences.
module tb_adder_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             LoadB;
  logic             Run;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] A, B, Sum;
  logic             CO, Busy, Done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the operand and result registers should hold.
  logic [WIDTH-1:0] m_a, m_b, m_sum;
  logic             m_co;

  adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadB (LoadB),
    .Run   (Run),
    .SW    (SW),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .CO    (CO),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_a"},   32'(A),   32'(m_a));
    chk({tag, "_b"},   32'(B),   32'(m_b));
    chk({tag, "_sum"}, 32'(Sum), 32'(m_sum));
    chk({tag, "_co"},  32'(CO),  32'(m_co));
  endtask

  task automatic press_loadb(input logic [WIDTH-1:0] val);
    SW    = val;
    LoadB = 1'b0;
    tick();
    tick();
    chk("b_before_k2", 32'(B), 32'(m_b));
    tick();
    m_b = val;
    chk("b_at_k2", 32'(B), 32'(m_b));
    LoadB = 1'b1;
    repeat (3) tick();
  endtask

  // Run press with SW=val; Run is held for 'hold' cycles after the Done pulse.
  task automatic run_add(input logic [WIDTH-1:0] val, input int hold,
                         input bit lb_same, input bit lb_mid, input logic [WIDTH-1:0] lb_val);
    logic [WIDTH:0] full;
    int dones;
    SW  = val;
    Run = 1'b0;
    if (lb_same) LoadB = 1'b0;
    tick();
    tick();
    chk("busy_before_k2", 32'(Busy), 0);
    tick();
    m_a = val;
    chk("busy_at_k2", 32'(Busy), 1);
    chk("a_at_k2", 32'(A), 32'(m_a));
    full = {1'b0, m_a} + {1'b0, m_b};
    dones = 0;
    for (int i = 1; i < N; i++) begin
      tick();
      if (lb_mid && i == 1) begin
        LoadB = 1'b0;
        SW    = lb_val;
      end
      dones += int'(Done);
    end
    chk("sum_held_in_add", 32'(Sum), 32'(m_sum));
    chk("busy_last_add", 32'(Busy), 1);
    tick();
    m_sum = full[WIDTH-1:0];
    m_co  = full[WIDTH];
`ifdef ADDSEQ_ACCUM_EN
    m_b = m_sum;
`endif
    chk("sum_at_done", 32'(Sum), 32'(m_sum));
    chk("co_at_done", 32'(CO), 32'(m_co));
    chk("busy_after_add", 32'(Busy), 0);
    chk("done_early", 32'(Done), 0);
    tick();
    chk("done_pulse", 32'(Done), 1);
    dones++;
    for (int j = 0; j < hold; j++) begin
      tick();
      if (j == 2) LoadB = 1'b1;
      dones += int'(Done);
    end
    Run   = 1'b1;
    LoadB = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      dones += int'(Done);
    end
    chk("done_count", 32'(dones), 1);
    check_regs("after_run");
  endtask

  initial begin
    Reset = 1'b1;
    LoadB = 1'b1;
    Run   = 1'b1;
    SW    = '0;
    m_a = '0; m_b = '0; m_sum = '0; m_co = 1'b0;
    repeat (3) tick();
    check_regs("reset");
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_done", 32'(Done), 0);
    Reset = 1'b0;
    repeat (2) tick();

    press_loadb(16'h000D);
    run_add(16'h0001, 4, 1'b0, 1'b0, '0);
    press_loadb(16'hFFFF);
    run_add(16'h0001, 4, 1'b0, 1'b0, '0);
    press_loadb(16'h00FF);
    run_add(16'h0001, 4, 1'b0, 1'b0, '0);
    run_add(16'h0F0F, 20, 1'b0, 1'b1, 16'h1234);

    press_loadb(16'h0000);
    for (int r = 0; r < 3; r++) run_add(16'h0001, 3, 1'b0, 1'b0, '0);

    // Reset during the second ADD cycle.
    SW  = 16'hABCD;
    Run = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    Run   = 1'b1;
    #1;
    m_a = '0; m_b = '0; m_sum = '0; m_co = 1'b0;
    check_regs("mid_add_reset");
    chk("mid_add_reset_busy", 32'(Busy), 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) tick();
    press_loadb(16'h8001);
    run_add(16'h7FFF, 3, 1'b0, 1'b0, '0);

    for (int t = 0; t < 30; t++) begin
      bit same, mid;
      same = ($urandom_range(0, 3) == 0);
      mid  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) press_loadb(WIDTH'($urandom));
      run_add(WIDTH'($urandom), $urandom_range(1, 6), same, mid, WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
